// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a circular buffer of
// {instr, pc2} entries with redirect flush and HALT lock. Optional macro FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  input  logic [15:0]   in_pc2,
  output logic          in_ready,
  output logic          out_valid,
  output logic [15:0]   out_instr,
  output logic [15:0]   out_pc2,
  input  logic          out_ready,
  input  logic          flush,
  output logic          halted,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the sender holds data while valid && !ready.

  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pc2_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          halt_q;

  logic full;
  logic empty;
  logic byp;
  logic push;
  logic pop;
  logic store;
  logic take;
  logic is_halt;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full && !halt_q && !flush;
  assign is_halt  = (in_instr[15:11] == 5'b00000);

`ifdef FETCHQ_BYPASS_EN
  // An arriving word may be shown directly when nothing is queued ahead of it.
  assign byp = empty && in_valid && in_ready && !rst;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = !flush && (!empty || byp);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A bypassed word consumed in the same cycle never touches storage.
  assign store     = push && !(byp && pop);
  assign take      = pop && !byp;

  always_comb begin
    out_instr = NOP_INSTR;
    out_pc2   = 16'h0000;
    if (out_valid) begin
      if (byp) begin
        out_instr = in_instr;
        out_pc2   = in_pc2;
      end else begin
        out_instr = instr_mem[rd_ptr];
        out_pc2   = pc2_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (take)  rd_ptr <= rd_ptr + AW'(1);
      case ({store, take})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && is_halt) halt_q <= 1'b1;
    end
  end

  // Entry storage is deliberately left unreset; only pointers define contents.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      instr_mem[wr_ptr] <= in_instr;
      pc2_mem[wr_ptr]   <= in_pc2;
    end
  end

  assign halted = halt_q;
  assign count  = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model. Honours FETCHQ_BYPASS_EN.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_instr;
  logic [15:0]   in_pc2;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc2;
  logic          out_ready;
  logic          flush;
  logic          halted;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  bit          m_halted = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc2(in_pc2), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc2(out_pc2), .out_ready(out_ready),
    .flush(flush), .halted(halted), .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Observed outputs packed as {in_ready, out_valid, out_instr, out_pc2, halted, count}.
  function automatic logic [37:0] obs();
    return {in_ready, out_valid, out_instr, out_pc2, halted, count};
  endfunction

  // Reference: what the queue must show this cycle given its contents and inputs.
  function automatic logic [37:0] model_exp();
    logic        rdy;
    logic        vld;
    logic        byp;
    logic [31:0] head;
    rdy = (mq.size() < DEPTH) && !m_halted && !flush;
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (mq.size() == 0) && in_valid && rdy && !rst;
`endif
    vld  = !flush && (mq.size() != 0 || byp);
    head = (mq.size() != 0) ? mq[0] : {in_instr, in_pc2};
    if (!vld) head = {16'h0800, 16'h0000};
    return {rdy, vld, head, m_halted, CW'(mq.size())};
  endfunction

  // Advance one clock, applying push-then-pop to the model queue.
  task automatic tick();
    logic [37:0] e;
    e = model_exp();
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
      m_halted = 1'b0;
    end else begin
      if (in_valid && e[37]) begin
        mq.push_back({in_instr, in_pc2});
        if (in_instr[15:11] == 5'b00000) m_halted = 1'b1;
      end
      if (e[36] && out_ready) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; in_instr = 16'h0; in_pc2 = 16'h0;
    out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] e;
    idle_inputs();
    rst = 1'b1; in_valid = 1'b1; in_instr = 16'h4ABC; in_pc2 = 16'h0010; out_ready = 1'b1;
    #1; tick();
    #1; e = model_exp();
    checks++;
    if (obs() !== 38'({1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0, 3'd0})) begin
      errors++; $display("FAIL reset_values: got %h exp %h", obs(), {1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0, 3'd0});
    end
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_model: got %h exp %h", obs(), e); end
    tick();
    idle_inputs();
  endtask

  task automatic test_fill_drain();
    logic [37:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 16'h4001 + 16'(i); in_pc2 = 16'(2 * (i + 1));
      #1; e = model_exp(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL fill cyc%0d: got %h exp %h", i, obs(), e); end
      tick();
    end
    in_instr = 16'h4005; in_pc2 = 16'd10;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
        errors++; $display("FAIL full_hold cyc%0d: got count=%0d in_ready=%b exp count=4 in_ready=0", i, count, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; e = model_exp(); checks++;
      if (out_valid !== 1'b1 || out_instr !== 16'h4001 + 16'(i) || out_pc2 !== 16'(2 * (i + 1))) begin
        errors++; $display("FAIL drain_order cyc%0d: got v=%b %h/%h exp v=1 %h/%h", i, out_valid, out_instr, out_pc2,
                           16'h4001 + 16'(i), 16'(2 * (i + 1)));
      end
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL drain cyc%0d: got %h exp %h", i, obs(), e); end
      tick();
    end
    #1; checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got count=%0d out_valid=%b exp 0/0", count, out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [37:0] e;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_instr = 16'h8000 | 16'($urandom_range(0, 16'h7FFF)); in_pc2 = 16'($urandom);
      out_ready = (i >= 2);
      #1; e = model_exp(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL wrap cyc%0d: got %h exp %h", i, obs(), e); end
      if (i >= 3) begin
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL wrap_count cyc%0d: got %0d exp 2", i, count); end
      end
      tick();
    end
    idle_inputs();
    flush = 1'b1; #1; tick(); flush = 1'b0;
  endtask

  task automatic test_halt();
    logic [37:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0000; in_pc2 = 16'h0100;
    #1; tick();
    in_instr = 16'hC123; in_pc2 = 16'h0102;
    for (int i = 0; i < 3; i++) begin
      #1; e = model_exp(); checks++;
      if (halted !== 1'b1 || in_ready !== 1'b0 || count !== 3'd1 || out_instr !== 16'h0000) begin
        errors++; $display("FAIL halt_lock cyc%0d: got h=%b r=%b c=%0d instr=%h exp 1/0/1/0000", i, halted, in_ready, count, out_instr);
      end
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL halt cyc%0d: got %h exp %h", i, obs(), e); end
      tick();
    end
    out_ready = 1'b1;
    #1; checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h0000 || out_pc2 !== 16'h0100) begin
      errors++; $display("FAIL halt_drain: got v=%b %h/%h exp 1 0000/0100", out_valid, out_instr, out_pc2);
    end
    tick();
    #1; checks++;
    if (out_valid !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_not_taken: got v=%b h=%b exp 0/1", out_valid, halted);
    end
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    #1; checks++;
    if (halted !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL halt_flush: got h=%b c=%0d r=%b exp 0/0/1", halted, count, in_ready);
    end
    idle_inputs();
  endtask

  task automatic test_flush_collision();
    logic [37:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 16'h5000 + 16'(i); in_pc2 = 16'(20 + 2 * i);
      #1; tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'hBEEF; in_pc2 = 16'h00EE; out_ready = 1'b1;
    #1; checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd3) begin
      errors++; $display("FAIL flush_cycle: got v=%b r=%b c=%0d exp 0/0/3", out_valid, in_ready, count);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; e = model_exp(); checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_instr === 16'hBEEF) begin
        errors++; $display("FAIL flush_after cyc%0d: got c=%0d v=%b instr=%h exp 0/0/0800", i, count, out_valid, out_instr);
      end
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL flush_model cyc%0d: got %h exp %h", i, obs(), e); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_instr = 16'hD9A0; in_pc2 = 16'h0042; out_ready = 1'b1;
    #1; checks++;
`ifdef FETCHQ_BYPASS_EN
    if (out_valid !== 1'b1 || out_instr !== 16'hD9A0 || out_pc2 !== 16'h0042 || count !== 3'd0) begin
      errors++; $display("FAIL bypass_same: got v=%b %h/%h c=%0d exp 1 D9A0/0042 0", out_valid, out_instr, out_pc2, count);
    end
`else
    if (out_valid !== 1'b0 || out_instr !== 16'h0800 || count !== 3'd0) begin
      errors++; $display("FAIL nobypass_same: got v=%b %h c=%0d exp 0 0800 0", out_valid, out_instr, count);
    end
`endif
    tick();
    in_valid = 1'b0;
    #1; checks++;
`ifdef FETCHQ_BYPASS_EN
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL bypass_next: got v=%b c=%0d exp 0/0", out_valid, count);
    end
`else
    if (out_valid !== 1'b1 || out_instr !== 16'hD9A0 || out_pc2 !== 16'h0042 || count !== 3'd1) begin
      errors++; $display("FAIL nobypass_next: got v=%b %h/%h c=%0d exp 1 D9A0/0042 1", out_valid, out_instr, out_pc2, count);
    end
`endif
    tick();
    idle_inputs();
    flush = 1'b1; #1; tick(); flush = 1'b0;
  endtask

  task automatic test_random();
    logic [37:0] e;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) in_instr[15:11] = 5'b00000;
      in_pc2    = 16'($urandom);
      #1; e = model_exp(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL random cyc%0d: got %h exp %h", i, obs(), e); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_halt();
    test_flush_collision();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the fetch stage (instruction memory plus PC+2 adder) and the decode stage, where the instruction-format classifier and control decode consume its output. It buffers up to DEPTH fetched 16-bit instructions with their PC+2 values, decouples fetch from decode stalls with a valid/ready handshake, discards contents on a control-flow redirect, and stops accepting fetches once a HALT has been enqueued.

## Interface
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- CW, 3, count width; equals log2(DEPTH)+1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  16  fetched instruction.
- in_pc2  in  16  PC+2 of that instruction.
- in_ready  out  1  queue accepts this cycle.
- out_valid  out  1  head entry valid for decode.
- out_instr  out  16  head instruction; 16'h0800 (NOP) when out_valid=0.
- out_pc2  out  16  head PC+2; 16'h0000 when out_valid=0.
- out_ready  in  1  decode consumes the head this cycle.
- flush  in  1  redirect; empties the queue.
- halted  out  1  HALT-lock active.
- count  out  CW  occupied entries, 0..DEPTH.

## Operation
- Storage: circular buffer, rd_ptr/wr_ptr of log2(DEPTH) bits that wrap from DEPTH-1 to 0; an occupancy counter derives full and empty.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = !full && !halted && !flush. While full, no push occurs even if a pop happens in the same cycle.
- The head is shown first-word-fall-through: out_instr and out_pc2 come straight from the rd_ptr entry.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- HALT detect: a pushed instruction with in_instr[15:11]==5'b00000 sets halted on the next edge. While halted is set, in_ready=0. Entries already queued, including the HALT itself, keep draining normally.
- Flush: has priority over push and pop. On the next edge count=0, both pointers=0, and halted=0. Any push or pop in the flush cycle is ignored, so the popped head is not consumed. out_valid is forced to 0 during the flush cycle.
- Reset: identical effect to flush. It is valid mid-operation and discards all entries.
- Entry storage is not cleared by reset or flush; only pointers and count are cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=16'h0800, out_pc2=16'h0000, halted=0, count=0.
- Latency without bypass: an instruction pushed in cycle N appears at out_valid in cycle N+1 at the earliest.
- in_ready, out_valid, and out_* depend only on registered state and flush. The only exception is the bypass path under FETCHQ_BYPASS_EN.
- halted asserts 1 cycle after the HALT push. in_ready drops in that same following cycle.
- After flush deasserts, in_ready=1 in the next cycle.

## Configuration
- FETCHQ_BYPASS_EN defined: when count=0, in_valid=1, and in_ready=1, the instruction passes combinationally.
  - out_valid=1, out_instr=in_instr, out_pc2=in_pc2 in the same cycle.
  - If out_ready=1, the instruction is consumed without being stored and count stays 0.
  - If out_ready=0, it is stored as a normal push.
  - A bypassed HALT still sets halted.
- Not defined: no combinational in-to-out path; the minimum latency is 1 cycle.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, out_instr=16'h0800, in_ready=1, count=0, halted=0.
- Fill and drain: out_ready=0, push 16'h4001, 16'h4002, 16'h4003, 16'h4004 with PC+2 values 2, 4, 6, 8.
  - Count reaches 4 and in_ready=0; a 5th word is held.
  - Then set out_ready=1 -> heads come out in order 4001..4004 with pc2 2..8, and count reaches 0.
- Wrap and concurrent push/pop: preload 2 entries, then push and pop every cycle for 10 cycles -> count stays 2, FIFO order holds across pointer wrap.
- HALT: push 16'h0000 followed by 16'hC123 -> halted=1 and in_ready=0 from the cycle after the HALT push; C123 is not accepted.
  - HALT still reaches out_instr.
  - A flush then gives halted=0, count=0.
- Flush collision: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed word never appears.
- Bypass (FETCHQ_BYPASS_EN): empty queue, in_valid=1, in_instr=16'hD9A0, out_ready=1 -> the same cycle gives out_valid=1, out_instr=16'hD9A0, and count remains 0.
  - Without the macro, the same stimulus gives out_valid=0 that cycle and 1 in the next cycle.
